reorder_buffer: RTL

- Circular in-order reorder buffer between the issue unit, the common data bus (CDB) and the architectural register file.
- Allocates one entry per issued instruction and hands its tag back to the issue unit.
- Captures out-of-order results from the CDB and retires at most one entry per cycle, in program order, onto the register-file commit port.
- Raises a one-cycle flush when a mispredicted branch retires.

---
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures CDB results,
// retires one entry per cycle to the register file and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    input  logic                issue_is_branch,
    output logic [ROB_BITS-1:0] issue_index,
    output logic                full,
    input  logic                cdb_valid,
    input  logic [ROB_BITS-1:0] cdb_index,
    input  logic [31:0]         cdb_value,
    input  logic                cdb_mispredict,
    input  logic [31:0]         cdb_target,
    input  logic [ROB_BITS-1:0] query1_index,
    input  logic [ROB_BITS-1:0] query2_index,
    output logic                query1_ready,
    output logic                query2_ready,
    output logic [31:0]         query1_value,
    output logic [31:0]         query2_value,
    output logic                commit_valid,
    output logic [ROB_BITS-1:0] commit_index,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic                flush,
    output logic [31:0]         flush_pc
);
    localparam int DEPTH = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0]   FULL_COUNT = {1'b1, {ROB_BITS{1'b0}}};
    localparam logic [ROB_BITS:0]   ZERO_COUNT = {(ROB_BITS+1){1'b0}};
    localparam logic [ROB_BITS-1:0] PTR_ZERO   = {ROB_BITS{1'b0}};
    localparam logic [ROB_BITS-1:0] PTR_ONE    = {{(ROB_BITS-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]    busy_r;
    logic [DEPTH-1:0]    ready_r;
    logic [DEPTH-1:0]    is_branch_r;
    logic [DEPTH-1:0]    mispredict_r;
    logic [4:0]          rd_r     [DEPTH];
    logic [31:0]         value_r  [DEPTH];
    logic [31:0]         target_r [DEPTH];
    logic [ROB_BITS-1:0] head_r;
    logic [ROB_BITS-1:0] tail_r;
    logic [ROB_BITS:0]   count_r;

    logic alloc_s;
    logic wb_s;
    logic commit_s;
    logic mis_s;
    logic q1_hit_s;
    logic q2_hit_s;

    assign full        = (count_r == FULL_COUNT);
    assign issue_index = tail_r;

    // Per-cycle event decode from pre-edge state; all events freeze while flush is high.
    always_comb begin
        alloc_s  = rdy & issue_valid & ~full & ~flush;
        wb_s     = rdy & cdb_valid & ~flush & busy_r[cdb_index];
        commit_s = rdy & ~flush & (count_r != ZERO_COUNT) & busy_r[head_r] & ready_r[head_r];
        mis_s    = commit_s & is_branch_r[head_r] & mispredict_r[head_r];
    end

    // Operand lookup with same-cycle CDB bypass; free tags never report ready.
    always_comb begin
        q1_hit_s     = cdb_valid & (cdb_index == query1_index);
        q2_hit_s     = cdb_valid & (cdb_index == query2_index);
        query1_ready = busy_r[query1_index] & (ready_r[query1_index] | q1_hit_s);
        query2_ready = busy_r[query2_index] & (ready_r[query2_index] | q2_hit_s);
        if (q1_hit_s) begin
            query1_value = cdb_value;
        end else begin
            query1_value = value_r[query1_index];
        end
        if (q2_hit_s) begin
            query2_value = cdb_value;
        end else begin
            query2_value = value_r[query2_index];
        end
    end

    // Control state, pointers and registered retire/flush outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= {DEPTH{1'b0}};
            ready_r      <= {DEPTH{1'b0}};
            head_r       <= PTR_ZERO;
            tail_r       <= PTR_ZERO;
            count_r      <= ZERO_COUNT;
            commit_valid <= 1'b0;
            commit_index <= PTR_ZERO;
            commit_rd    <= 5'd0;
            commit_value <= 32'd0;
            flush        <= 1'b0;
            flush_pc     <= 32'd0;
        end else if (rdy) begin
            commit_valid <= commit_s;
            flush        <= mis_s;
            if (commit_s) begin
                commit_index <= head_r;
                commit_rd    <= rd_r[head_r];
                commit_value <= value_r[head_r];
            end
            if (mis_s) begin
                // Mispredict wipes everything, including any same-edge issue or writeback.
                flush_pc <= target_r[head_r];
                busy_r   <= {DEPTH{1'b0}};
                ready_r  <= {DEPTH{1'b0}};
                head_r   <= PTR_ZERO;
                tail_r   <= PTR_ZERO;
                count_r  <= ZERO_COUNT;
            end else begin
                if (wb_s) begin
                    ready_r[cdb_index] <= 1'b1;
                end
                if (alloc_s) begin
                    busy_r[tail_r]  <= 1'b1;
                    ready_r[tail_r] <= 1'b0;
                    tail_r          <= tail_r + PTR_ONE;
                end
                if (commit_s) begin
                    busy_r[head_r] <= 1'b0;
                    head_r         <= head_r + PTR_ONE;
                end
                count_r <= count_r + (ROB_BITS+1)'(alloc_s) - (ROB_BITS+1)'(commit_s);
            end
        end
    end

    // Entry payload; validity is tracked by busy/ready so no reset is needed here.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            rd_r[tail_r]         <= issue_rd;
            is_branch_r[tail_r]  <= issue_is_branch;
            mispredict_r[tail_r] <= 1'b0;
        end
        if (wb_s) begin
            value_r[cdb_index]      <= cdb_value;
            target_r[cdb_index]     <= cdb_target;
            mispredict_r[cdb_index] <= cdb_mispredict;
        end
    end
endmodule
